wordcount_accum: RTL and testbench
==================================

Name: wordcount_accum

Overview:
- Downstream consumer of the search-and-add stage's accumulate stream (addr/din/we) in the word-count pipeline.
- Keeps a table of {key value, count} per CAM entry address and adds each increment by read-modify-write.
- On request, streams the populated table out over a valid/ready interface, optionally clearing it afterwards.
- Clears the table itself after reset.

Parameters:
- ADDR_W, 10, table index width; DEPTH = 2**ADDR_W entries.
- CNT_W, 32, count width; the count saturates.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- accum_addr  in  32  entry address; bits [ADDR_W-1:0] index the table.
- accum_din  in  64  [63:32] key value, [31:0] increment.
- accum_we  in  1  one accumulate request per asserted cycle; no backpressure.
- ready  out  1  high only in IDLE with the clear finished.
- dump_kick  in  1  pulse: start a dump.
- dump_clear  in  1  sampled with dump_kick; 1 = clear the table after the dump.
- busy  out  1  high from dump_kick acceptance until the state returns to IDLE.
- dump_addr  out  ADDR_W  table index of the current output word.
- dump_data  out  64  {key[31:0], count[31:0]}.
- dump_valid  out  1  output word valid.
- dump_ready  in  1  consumer accepts the word when dump_valid and dump_ready are both high.
- dump_last  out  1  marks the final word of a dump.
- err  out  3  sticky flags, cleared only by reset: [0] address out of range, [1] write dropped (not IDLE), [2] key mismatch.

Behaviour:
- Reset:
  - All outputs go to 0.
  - State goes to CLEAR; the pipeline is flushed; hw_valid=0 and hwm=0.
  - Reset mid-dump abandons the dump with no dump_last.
- CLEAR:
  - Writes 0 to one entry per cycle, index 0..DEPTH-1, which takes DEPTH cycles.
  - Then goes to IDLE; ready rises on the first IDLE cycle.
- Accumulate pipeline, IDLE only:
  - S0: register the request and issue a RAM read (1-cycle synchronous read).
  - S1: merge and write back.
  - Full throughput: one request per cycle.
  - Write-back lands 2 cycles after accum_we.
- Forwarding:
  - If the S0 index equals the S1 index being written, S0 uses the S1 write data instead of the RAM output.
  - Back-to-back hits on the same index therefore accumulate exactly.
- Merge rules:
  - Stored count 0: entry becomes {key_in, inc}.
  - Stored count nonzero: stored key is kept; count = min(count + inc, 2**CNT_W - 1).
  - Stored count nonzero and stored key != key_in: set err[2]; the count is still updated.
- Rejects and high-water mark:
  - accum_addr[31:ADDR_W] != 0: request dropped, err[0] set.
  - accum_we while not IDLE: request dropped, err[1] set.
  - hwm tracks the maximum accepted index, and hw_valid is set on the first accepted request; hw_valid/hwm is the dump range.
- Dump FSM (IDLE → DRAIN → RD → OUT → … → CLEAR or IDLE):
  - dump_kick in IDLE: busy=1 next cycle, go to DRAIN.
  - DRAIN: wait until S0/S1 are empty (at most 2 cycles).
  - If hw_valid=0: produce no output words; go to CLEAR if dump_clear was latched, else IDLE.
  - RD: read the entry at index i, starting from 0.
  - OUT: dump_valid=1; dump_data and dump_addr hold steady until the handshake; dump_last=1 when i==hwm.
  - After a handshake: if i==hwm, go to CLEAR if dump_clear was latched, else IDLE; otherwise i++ and go to RD.
  - Throughput is at most one word per 2 cycles.
  - Zero-count entries inside [0,hwm] are still emitted.
  - dump_kick outside IDLE is ignored.
  - The post-dump CLEAR resets hw_valid/hwm; busy stays high until IDLE.
- Simultaneous events:
  - accum_we and dump_kick in the same IDLE cycle: the write is accepted and drains in DRAIN.
  - dump_ready held high: a word is consumed the same cycle dump_valid rises.

Decomposition:
- Package wordcount_pkg:
  - entry_t packed struct {key[31:0], cnt[CNT_W-1:0]}.
  - state_t enum {CLEAR, IDLE, DRAIN, RD, OUT}.
  - err bit-index constants.
  - Shared with the search-and-add stage, which gets the accum_din field offsets.
- Sub-module wc_entry_ram:
  - Simple dual-port RAM: one write port, one read port, registered read, DEPTH x 64.
  - Inferable as BRAM.

Test Plan:
- Reset release → ready=0 for DEPTH cycles, then 1; a dump with no writes produces no output words and busy falls; err=0.
- Writes addr 5 {key 0xAA, inc 1} in 3 consecutive cycles, then dump → words for idx 0..5; idx 5 = {0xAA, 3} with dump_last=1; idx 0..4 = 0.
- Alternating addr 1/2/1/2 back-to-back, then a write to addr 1 with key 0xBB after key 0xAA → idx1 count 3 keeps key 0xAA; err[2]=1; idx2 count 2.
- addr 5 preset count 0xFFFFFFFE, inc 5 → count 0xFFFFFFFF; addr 0x400 (ADDR_W=10) → dropped, err[0]=1.
- Dump with dump_ready toggling randomly → every word is held stable while stalled; no loss or duplicates; an accum_we during the dump sets err[1] and leaves the table unchanged.
- dump_clear=1: dump, then a second dump → the second dump produces no output words; reset asserted mid-OUT → dump_valid=0 next cycle, CLEAR restarts.

Source files
------------

// File: rtl/wordcount_pkg.sv
// Shared types for the word-count pipeline: the table entry layout, the
// accumulate-stream field offsets and the sticky error bit positions.
package wordcount_pkg;

    localparam int KEY_W       = 32;
    localparam int ENTRY_CNT_W = 32;

    // accum_din layout: [63:32] key value, [31:0] increment
    localparam int DIN_KEY_LSB = 32;
    localparam int DIN_INC_LSB = 0;
    localparam int DIN_INC_W   = 32;

    localparam int ERR_RANGE = 0;
    localparam int ERR_DROP  = 1;
    localparam int ERR_KEY   = 2;

    typedef struct packed {
        logic [KEY_W-1:0]       key;
        logic [ENTRY_CNT_W-1:0] cnt;
    } entry_t;

    typedef enum logic [2:0] {CLEAR, IDLE, DRAIN, RD, OUT} state_t;

endpackage

// File: rtl/wc_entry_ram.sv
// Count table storage: one write port, one registered read port.
// Read-during-write to the same index returns the old word.
module wc_entry_ram
    import wordcount_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [$bits(entry_t)-1:0]   wdata,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [$bits(entry_t)-1:0]   rdata
);

    logic [$bits(entry_t)-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/wordcount_accum.sv
// Word-count table: read-modify-write accumulation of {key, count} per entry,
// with a valid/ready dump of the populated range and optional clear.
module wordcount_accum
    import wordcount_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       accum_addr,
    input  logic [63:0]       accum_din,
    input  logic              accum_we,
    output logic              ready,
    input  logic              dump_kick,
    input  logic              dump_clear,
    output logic              busy,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [63:0]       dump_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic              dump_last,
    output logic [2:0]        err
);

    localparam int DEPTH = 2**ADDR_W;

    function automatic logic [ENTRY_CNT_W-1:0] sat_add(input logic [ENTRY_CNT_W-1:0] a,
                                                       input logic [DIN_INC_W-1:0]   b);
        logic [ENTRY_CNT_W:0] sum;
        logic [ENTRY_CNT_W:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = ((ENTRY_CNT_W+1)'(1) << CNT_W) - (ENTRY_CNT_W+1)'(1);
        return (sum > lim) ? lim[ENTRY_CNT_W-1:0] : sum[ENTRY_CNT_W-1:0];
    endfunction

    state_t             state;
    logic [ADDR_W-1:0]  clr_idx;
    logic [ADDR_W-1:0]  dump_idx;
    logic [ADDR_W-1:0]  hwm;
    logic               hw_valid;
    logic               clr_lat;
    logic               dump_done;

    logic               vld_p0, vld_p1;
    logic [ADDR_W-1:0]  idx_p0, idx_p1;
    logic [KEY_W-1:0]   key_p0;
    logic [DIN_INC_W-1:0] inc_p0;
    entry_t             ent_p1, old_p0, new_p0, ram_rdata, ram_wdata;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_waddr, ram_raddr;
    logic               in_range, acc_ok;
    logic [ADDR_W-1:0]  acc_idx;

    assign in_range = (accum_addr[31:ADDR_W] == '0);
    assign acc_idx  = accum_addr[ADDR_W-1:0];
    assign acc_ok   = accum_we && in_range && (state == IDLE);

    // Table port muxing: CLEAR owns the write port, IDLE owns the read port
    always_comb begin
        ram_we    = (state == CLEAR) || vld_p0;
        ram_waddr = (state == CLEAR) ? clr_idx : idx_p0;
        ram_wdata = (state == CLEAR) ? '0 : new_p0;
        ram_raddr = (state == IDLE) ? acc_idx : dump_idx;
    end

    wc_entry_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // p0 -> p1: merge against the read word, forwarding the entry written last cycle
    always_comb begin
        old_p0     = (vld_p1 && (idx_p1 == idx_p0)) ? ent_p1 : ram_rdata;
        new_p0.key = (old_p0.cnt == '0) ? key_p0 : old_p0.key;
        new_p0.cnt = sat_add(old_p0.cnt, inc_p0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= acc_ok;
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_ok) begin
            idx_p0 <= acc_idx;
            key_p0 <= accum_din[DIN_KEY_LSB +: KEY_W];
            inc_p0 <= accum_din[DIN_INC_LSB +: DIN_INC_W];
        end
        idx_p1 <= idx_p0;
        ent_p1 <= new_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= '0;
        end else begin
            if (accum_we && !in_range)   err[ERR_RANGE] <= 1'b1;
            if (accum_we && state != IDLE) err[ERR_DROP] <= 1'b1;
            if (vld_p0 && old_p0.cnt != '0 && old_p0.key != key_p0) err[ERR_KEY] <= 1'b1;
        end
    end

    assign dump_done = (state == DRAIN && !vld_p0 && !vld_p1 && !hw_valid) ||
                       (state == OUT && dump_ready && dump_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            dump_idx   <= '0;
            hwm        <= '0;
            hw_valid   <= 1'b0;
            clr_lat    <= 1'b0;
            ready      <= 1'b0;
            busy       <= 1'b0;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
        end else begin
            if (acc_ok) begin
                hw_valid <= 1'b1;
                if (!hw_valid || acc_idx > hwm) hwm <= acc_idx;
            end
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == ADDR_W'(DEPTH-1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (dump_kick) begin
                        state   <= DRAIN;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                        clr_lat <= dump_clear;
                    end
                end
                DRAIN: begin
                    if (!vld_p0 && !vld_p1 && hw_valid) begin
                        state    <= RD;
                        dump_idx <= '0;
                    end
                end
                RD: begin
                    state      <= OUT;
                    dump_valid <= 1'b1;
                    dump_last  <= (dump_idx == hwm);
                end
                OUT: begin
                    if (dump_ready) begin
                        dump_valid <= 1'b0;
                        dump_last  <= 1'b0;
                        if (!dump_last) begin
                            dump_idx <= dump_idx + 1'b1;
                            state    <= RD;
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
            if (dump_done) begin
                dump_idx <= '0;
                if (clr_lat) begin
                    state    <= CLEAR;
                    clr_idx  <= '0;
                    hw_valid <= 1'b0;
                    hwm      <= '0;
                end else begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            end
        end
    end

    assign dump_addr = dump_idx;
    assign dump_data = dump_valid ? ram_rdata : '0;

endmodule

// File: tb/tb_wordcount_accum.sv
// Directed bench for wordcount_accum: clear timing, accumulation, forwarding,
// key mismatch, saturation, rejects, stalled dumps, clear-after-dump, reset mid-dump.
module tb_wordcount_accum;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       accum_addr;
    logic [63:0]       accum_din;
    logic              accum_we;
    logic              ready;
    logic              dump_kick;
    logic              dump_clear;
    logic              busy;
    logic [ADDR_W-1:0] dump_addr;
    logic [63:0]       dump_data;
    logic              dump_valid;
    logic              dump_ready;
    logic              dump_last;
    logic [2:0]        err;

    int checks = 0;
    int passes = 0;

    logic [63:0]       got_data [64];
    logic [ADDR_W-1:0] got_addr [64];
    logic              got_last [64];
    logic [63:0]       exp_data [8];
    int                n_words;

    wordcount_accum #(.ADDR_W(ADDR_W), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .accum_addr (accum_addr),
        .accum_din  (accum_din),
        .accum_we   (accum_we),
        .ready      (ready),
        .dump_kick  (dump_kick),
        .dump_clear (dump_clear),
        .busy       (busy),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_last  (dump_last),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic acc(input logic [31:0] addr, input logic [31:0] key, input logic [31:0] inc);
        accum_addr = addr;
        accum_din  = {key, inc};
        accum_we   = 1'b1;
        tick();
        accum_we   = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic do_dump(input bit clr, input bit rnd, input bit inject);
        int          cyc;
        bit          stalled;
        logic [63:0] held_data;
        logic [ADDR_W-1:0] held_addr;
        n_words    = 0;
        stalled    = 1'b0;
        held_data  = '0;
        held_addr  = '0;
        dump_kick  = 1'b1;
        dump_clear = clr;
        dump_ready = 1'b0;
        tick();
        dump_kick  = 1'b0;
        dump_clear = 1'b0;
        accum_we   = 1'b0;
        chk("busy_rise", 64'(busy), 64'd1);
        cyc = 0;
        while (busy && cyc < 4000) begin
            if (stalled) begin
                chk("hold_valid", 64'(dump_valid), 64'd1);
                chk("hold_data", dump_data, held_data);
                chk("hold_addr", 64'(dump_addr), 64'(held_addr));
            end
            stalled    = 1'b0;
            dump_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && cyc == 2) begin
                accum_addr = 32'd5;
                accum_din  = {32'hAA, 32'd1};
                accum_we   = 1'b1;
            end
            if (dump_valid) begin
                if (dump_ready) begin
                    if (n_words < 64) begin
                        got_data[n_words] = dump_data;
                        got_addr[n_words] = dump_addr;
                        got_last[n_words] = dump_last;
                    end
                    n_words++;
                end else begin
                    stalled   = 1'b1;
                    held_data = dump_data;
                    held_addr = dump_addr;
                end
            end
            tick();
            accum_we = 1'b0;
            cyc++;
        end
        dump_ready = 1'b0;
        chk("dump_terminates", 64'(cyc < 4000), 64'd1);
    endtask

    task automatic check_dump(input string tag, input int n_exp);
        chk({tag, "_nwords"}, 64'(n_words), 64'(n_exp));
        for (int i = 0; i < n_exp && i < n_words && i < 8; i++) begin
            chk({tag, "_addr"}, 64'(got_addr[i]), 64'(i));
            chk({tag, "_data"}, got_data[i], exp_data[i]);
            chk({tag, "_last"}, 64'(got_last[i]), 64'(i == n_exp - 1));
        end
    endtask

    initial begin
        int n;
        reset      = 1'b1;
        accum_addr = '0;
        accum_din  = '0;
        accum_we   = 1'b0;
        dump_kick  = 1'b0;
        dump_clear = 1'b0;
        dump_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_last", 64'(dump_last), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        reset = 1'b0;

        // Initial clear takes exactly DEPTH cycles
        wait_ready(n);
        chk("clear_cycles", 64'(n), 64'(DEPTH));

        // Dump with no writes yields nothing
        do_dump(1'b0, 1'b0, 1'b0);
        chk("empty_nwords", 64'(n_words), 64'd0);
        chk("empty_ready", 64'(ready), 64'd1);
        chk("empty_err", 64'(err), 64'd0);

        // Three hits on index 5; the third coincides with dump_kick
        acc(32'd5, 32'hAA, 32'd1);
        acc(32'd5, 32'hAA, 32'd1);
        accum_addr = 32'd5;
        accum_din  = {32'hAA, 32'd1};
        accum_we   = 1'b1;
        do_dump(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) exp_data[i] = '0;
        exp_data[5] = {32'hAA, 32'd3};
        check_dump("t2", 6);
        chk("t2_err", 64'(err), 64'd0);

        // Alternating indices back-to-back, then a key mismatch on index 1
        acc(32'd1, 32'hAA, 32'd1);
        acc(32'd2, 32'hAA, 32'd1);
        acc(32'd1, 32'hAA, 32'd1);
        acc(32'd2, 32'hAA, 32'd1);
        acc(32'd1, 32'hBB, 32'd1);
        tick(); tick();
        chk("t3_err", 64'(err), 64'b100);
        do_dump(1'b1, 1'b0, 1'b0);
        exp_data[1] = {32'hAA, 32'd3};
        exp_data[2] = {32'hAA, 32'd2};
        check_dump("t3", 6);

        // Saturation through the forwarding path, then an out-of-range address
        acc(32'd5, 32'hAA, 32'hFFFF_FFFE);
        acc(32'd5, 32'hAA, 32'd5);
        acc(32'h400, 32'hAA, 32'd1);
        tick(); tick();
        chk("t4_err", 64'(err), 64'b101);

        // Stalled dump with a write injected mid-dump, clearing afterwards
        do_dump(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) exp_data[i] = '0;
        exp_data[5] = {32'hAA, 32'hFFFF_FFFF};
        check_dump("t5", 6);
        chk("t5_err", 64'(err), 64'b111);
        chk("t5_ready", 64'(ready), 64'd1);

        // After a clearing dump the next dump is empty
        do_dump(1'b0, 1'b0, 1'b0);
        chk("t6_nwords", 64'(n_words), 64'd0);

        // Reset while a word is being offered
        acc(32'd3, 32'h11, 32'd7);
        tick();
        dump_kick  = 1'b1;
        dump_ready = 1'b0;
        tick();
        dump_kick = 1'b0;
        n = 0;
        while (!dump_valid && n < 20) begin
            tick();
            n++;
        end
        chk("t7_valid_up", 64'(dump_valid), 64'd1);
        reset = 1'b1;
        tick();
        chk("t7_valid_dn", 64'(dump_valid), 64'd0);
        chk("t7_last", 64'(dump_last), 64'd0);
        chk("t7_busy", 64'(busy), 64'd0);
        chk("t7_ready", 64'(ready), 64'd0);
        chk("t7_err", 64'(err), 64'd0);
        reset = 1'b0;
        wait_ready(n);
        chk("t7_clear_cycles", 64'(n), 64'(DEPTH));
        do_dump(1'b0, 1'b0, 1'b0);
        chk("t7_nwords", 64'(n_words), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
